seq_bit_serializer: RTL

//  Parallel-to-serial stimulus stage that sits directly upstream of the serial

---
 rtl/seq_bit_serializer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stimulus stage feeding the serial sequence detector.
// A word of up to WIDTH bits is accepted over valid/ready. It is then shifted
// out one registered bit per clk, and ser_valid qualifies each bit. Words can
// follow each other with no idle cycle between them. done marks the last bit
// of each word, and len_err flags a dropped zero-length word.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | nothing on the wire; ser_out=IDLE_BIT; ready for a new word
// S_SHIFT | a word bit is on ser_out; cnt = bits left including this one;
//         | ready only while the last bit is being presented (cnt==1)
module seq_bit_serializer #(
  parameter int   WIDTH     = 14,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0,
  localparam int  LW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [LW-1:0] CNT_ZERO = LW'(0);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);
  localparam logic [LW-1:0] CNT_TWO  = LW'(2);
  localparam logic [LW-1:0] WIDTH_L  = LW'(WIDTH);

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             ser_out_d;
  logic             ser_valid_d;
  logic             done_d;
  logic             len_err_d;

  logic             handshake;
  logic [LW-1:0]    len_eff;
  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] sh_adv;

  // The shift register always holds the bits still to be sent, with the next
  // bit at the outgoing end. Bit order is fixed by the parameter, so only the
  // end that is tapped and the shift direction differ.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit = load_data[WIDTH-1];
      assign load_rest = {load_data[WIDTH-2:0], 1'b0};
      assign next_bit  = sh_q[WIDTH-1];
      assign sh_adv    = {sh_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit = load_data[0];
      assign load_rest = {1'b0, load_data[WIDTH-1:1]};
      assign next_bit  = sh_q[0];
      assign sh_adv    = {1'b0, sh_q[WIDTH-1:1]};
    end
  endgenerate

  // Lengths beyond the register width are clamped rather than rejected.
  assign len_eff = (load_len > WIDTH_L) ? WIDTH_L : load_len;

  // Ready depends only on state and count. This lets an upstream block use
  // ready to decide on valid without forming a combinational loop.
  assign load_ready = (state_q == S_IDLE) || (cnt_q == CNT_ONE);
  assign handshake  = load_valid && load_ready;
  assign busy       = (state_q == S_SHIFT);

  // Next-state and next-output logic. On an accepted word, its first bit is
  // loaded at the accepting edge, so the word starts with zero latency.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ser_out_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    len_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if (len_eff == CNT_ZERO) begin
            len_err_d = 1'b1;
          end else begin
            ser_out_d   = first_bit;
            ser_valid_d = 1'b1;
            sh_d        = load_rest;
            cnt_d       = len_eff;
            done_d      = (len_eff == CNT_ONE);
            state_d     = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (cnt_q != CNT_ONE) begin
          ser_out_d   = next_bit;
          ser_valid_d = 1'b1;
          sh_d        = sh_adv;
          cnt_d       = cnt_q - CNT_ONE;
          done_d      = (cnt_q == CNT_TWO);
        end else if (handshake && (len_eff != CNT_ZERO)) begin
          ser_out_d   = first_bit;
          ser_valid_d = 1'b1;
          sh_d        = load_rest;
          cnt_d       = len_eff;
          done_d      = (len_eff == CNT_ONE);
        end else begin
          len_err_d = handshake;
          cnt_d     = CNT_ZERO;
          state_d   = S_IDLE;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and all outputs except load_ready are registered here.
  // This keeps ser_out stable for a whole cycle at the detector input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      sh_q      <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      done      <= done_d;
      len_err   <= len_err_d;
    end
  end

endmodule
